// File: rtl/vdp_line_pingpong.sv
// Double-buffered scanline store: the renderer fills the back bank over valid/ready
// while scanout reads the front bank by address; a per-line pulse exchanges the banks.
module vdp_line_pingpong #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 512,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int LINE_LEN = DEPTH,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swap_i,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic              fill_done_o,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              front_o,
    output logic              underrun_o,
    input  logic              clr_err_i
);

    localparam logic [ADDR_W:0] LINE_LEN_C = (ADDR_W+1)'(LINE_LEN);
    localparam logic [ADDR_W:0] LAST_C     = (ADDR_W+1)'(LINE_LEN - 1);

    logic              front_q, front_d;
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic              fill_done_q, fill_done_d;
    logic              underrun_q, underrun_d;
    logic              wr_fire;
    logic [ADDR_W:0]   wr_addr;
    logic [ADDR_W:0]   rd_addr;

    logic [DATA_W-1:0] mem [2*DEPTH];
    logic [DATA_W-1:0] mem_rd_q;
    logic              rd_v1_q;
    logic              rd_zero_q;
    logic [DATA_W-1:0] rd1_data;

    // wptr carries one extra bit so a full line (wptr == LINE_LEN) is representable.
    assign wr_ready_o = !rst && (wptr_q < LINE_LEN_C);
    assign wr_fire    = wr_valid_i && wr_ready_o;
    assign wr_addr    = {~front_q, wptr_q[ADDR_W-1:0]};
    assign rd_addr    = {front_q, rd_addr_i};

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        front_d     = front_q;
        wptr_d      = wptr_q;
        fill_done_d = fill_done_q;
        underrun_d  = underrun_q;
        if (wr_fire) begin
            wptr_d = wptr_q + 1'b1;
            if (wptr_q == LAST_C) fill_done_d = 1'b1;
        end
        if (clr_err_i) underrun_d = 1'b0;
        // NOTE: blocking assignments here, so the swap block placed last wins over write/clear.
        if (swap_i) begin
            front_d     = ~front_q;
            wptr_d      = '0;
            fill_done_d = 1'b0;
            if (!fill_done_q) underrun_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            front_q     <= 1'b0;
            wptr_q      <= '0;
            fill_done_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            front_q     <= front_d;
            wptr_q      <= wptr_d;
            fill_done_q <= fill_done_d;
            underrun_q  <= underrun_d;
        end
    end

    // NOTE: storage and its read register carry no reset so they map onto a single SDP BRAM.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_addr] <= wr_data_i;
        if (rd_en_i) mem_rd_q <= mem[rd_addr];
    end

    // rd_zero_q resets high so the output reads 0 without resetting the BRAM register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v1_q   <= 1'b0;
            rd_zero_q <= 1'b1;
        end else begin
            rd_v1_q <= rd_en_i;
            if (rd_en_i) rd_zero_q <= ({1'b0, rd_addr_i} >= LINE_LEN_C);
        end
    end

    assign rd1_data = rd_zero_q ? '0 : mem_rd_q;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              rd_v2_q;
            logic [DATA_W-1:0] rd_data2_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_v2_q    <= 1'b0;
                    rd_data2_q <= '0;
                end else begin
                    rd_v2_q <= rd_v1_q;
                    if (rd_v1_q) rd_data2_q <= rd1_data;
                end
            end
            assign rd_valid_o = rd_v2_q;
            assign rd_data_o  = rd_data2_q;
        end else begin : g_lat1
            assign rd_valid_o = rd_v1_q;
            assign rd_data_o  = rd1_data;
        end
    endgenerate

    assign front_o     = front_q;
    assign fill_done_o = fill_done_q;
    assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_vdp_line_pingpong.sv
// Directed bench: one-cycle and two-cycle read-latency builds share the same stimulus.
module tb_vdp_line_pingpong;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 4;
    localparam int LINE_LEN = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              swap_i, wr_valid_i, rd_en_i, clr_err_i;
    logic [DATA_W-1:0] wr_data_i;
    logic [ADDR_W-1:0] rd_addr_i;

    logic              l1_wr_ready, l1_fill_done, l1_rd_valid, l1_front, l1_underrun;
    logic [DATA_W-1:0] l1_rd_data;
    logic              l2_wr_ready, l2_fill_done, l2_rd_valid, l2_front, l2_underrun;
    logic [DATA_W-1:0] l2_rd_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vdp_line_pingpong #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                        .LINE_LEN(LINE_LEN), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .swap_i(swap_i), .wr_valid_i(wr_valid_i),
        .wr_data_i(wr_data_i), .wr_ready_o(l1_wr_ready), .fill_done_o(l1_fill_done),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(l1_rd_data),
        .rd_valid_o(l1_rd_valid), .front_o(l1_front), .underrun_o(l1_underrun),
        .clr_err_i(clr_err_i)
    );

    vdp_line_pingpong #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                        .LINE_LEN(LINE_LEN), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .swap_i(swap_i), .wr_valid_i(wr_valid_i),
        .wr_data_i(wr_data_i), .wr_ready_o(l2_wr_ready), .fill_done_o(l2_fill_done),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(l2_rd_data),
        .rd_valid_o(l2_rd_valid), .front_o(l2_front), .underrun_o(l2_underrun),
        .clr_err_i(clr_err_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_line(input logic [31:0] base, input int count);
        for (int i = 0; i < count; i++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = base + 32'(i);
            step();
        end
        wr_valid_i = 1'b0;
    endtask

    task automatic do_swap();
        swap_i = 1'b1;
        step();
        swap_i = 1'b0;
    endtask

    task automatic clear_err();
        clr_err_i = 1'b1;
        step();
        clr_err_i = 1'b0;
    endtask

    // Single read: latency-1 result after one edge, latency-2 result after two, then hold.
    task automatic read_one(input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
        rd_en_i   = 1'b1;
        rd_addr_i = addr;
        step();
        rd_en_i = 1'b0;
        check("rd1_valid", {31'b0, l1_rd_valid}, 32'd1);
        check("rd1_data", l1_rd_data, exp);
        check("rd2_early", {31'b0, l2_rd_valid}, 32'd0);
        step();
        check("rd2_valid", {31'b0, l2_rd_valid}, 32'd1);
        check("rd2_data", l2_rd_data, exp);
        check("rd1_idle", {31'b0, l1_rd_valid}, 32'd0);
        check("rd1_hold", l1_rd_data, exp);
    endtask

    int n_acc;
    logic acc;

    initial begin
        rst = 1'b1; swap_i = 1'b0; wr_valid_i = 1'b0; rd_en_i = 1'b0; clr_err_i = 1'b0;
        wr_data_i = '0; rd_addr_i = '0;

        // Reset
        step();
        check("rst_ready", {31'b0, l1_wr_ready}, 32'd0);
        step();
        check("rst_front", {31'b0, l1_front}, 32'd0);
        check("rst_fill", {31'b0, l1_fill_done}, 32'd0);
        check("rst_underrun", {31'b0, l1_underrun}, 32'd0);
        check("rst_rv1", {31'b0, l1_rd_valid}, 32'd0);
        check("rst_rv2", {31'b0, l2_rd_valid}, 32'd0);
        check("rst_rd1", l1_rd_data, 32'd0);
        check("rst_rd2", l2_rd_data, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'b0, l1_wr_ready}, 32'd1);

        // Fill + swap + streamed read
        for (int i = 0; i < LINE_LEN; i++) begin
            check("fill_ready", {31'b0, l1_wr_ready}, 32'd1);
            check("fill_not_done", {31'b0, l1_fill_done}, 32'd0);
            wr_valid_i = 1'b1;
            wr_data_i  = 32'h100 + 32'(i);
            step();
        end
        wr_valid_i = 1'b0;
        check("fill_done", {31'b0, l1_fill_done}, 32'd1);
        check("fill_done2", {31'b0, l2_fill_done}, 32'd1);
        check("full_ready", {31'b0, l1_wr_ready}, 32'd0);
        do_swap();
        check("swap_front", {31'b0, l1_front}, 32'd1);
        check("swap_fill_clr", {31'b0, l1_fill_done}, 32'd0);
        check("swap_no_underrun", {31'b0, l1_underrun}, 32'd0);
        for (int c = 0; c < LINE_LEN + 2; c++) begin
            rd_en_i   = (c < LINE_LEN);
            rd_addr_i = ADDR_W'(c);
            step();
            if (c < LINE_LEN) begin
                check("stream1_valid", {31'b0, l1_rd_valid}, 32'd1);
                check("stream1_data", l1_rd_data, 32'h100 + 32'(c));
            end else begin
                check("stream1_end", {31'b0, l1_rd_valid}, 32'd0);
            end
            if (c >= 1 && c <= LINE_LEN) begin
                check("stream2_valid", {31'b0, l2_rd_valid}, 32'd1);
                check("stream2_data", l2_rd_data, 32'h100 + 32'(c - 1));
            end else begin
                check("stream2_idle", {31'b0, l2_rd_valid}, 32'd0);
            end
        end
        rd_en_i = 1'b0;

        // Back-pressure: valid held for 10 cycles, only a line's worth is taken
        n_acc      = 0;
        wr_valid_i = 1'b1;
        wr_data_i  = 32'h200;
        for (int i = 0; i < 10; i++) begin
            acc = l1_wr_ready;
            step();
            if (acc) begin
                n_acc++;
                wr_data_i = 32'h200 + 32'(n_acc);
            end
        end
        check("bp_count", 32'(n_acc), 32'd8);
        check("bp_ready", {31'b0, l1_wr_ready}, 32'd0);
        check("bp_ready2", {31'b0, l2_wr_ready}, 32'd0);
        do_swap();
        check("bp_ready_after_swap", {31'b0, l1_wr_ready}, 32'd1);
        step();
        wr_valid_i = 1'b0;
        check("bp_no_underrun", {31'b0, l1_underrun}, 32'd0);
        read_one(4'd0, 32'h200);
        read_one(4'd7, 32'h207);
        write_line(32'h209, 7);
        check("bp_fill_done", {31'b0, l1_fill_done}, 32'd1);
        do_swap();
        read_one(4'd0, 32'h208);
        read_one(4'd1, 32'h209);
        read_one(4'd7, 32'h20F);

        // Underrun
        write_line(32'h300, 5);
        check("ur_partial", {31'b0, l1_fill_done}, 32'd0);
        do_swap();
        check("ur_set", {31'b0, l1_underrun}, 32'd1);
        check("ur_front", {31'b0, l1_front}, 32'd0);
        write_line(32'h400, 8);
        do_swap();
        check("ur_sticky", {31'b0, l1_underrun}, 32'd1);
        clear_err();
        check("ur_clear", {31'b0, l1_underrun}, 32'd0);
        write_line(32'h410, 3);
        clr_err_i = 1'b1;
        swap_i    = 1'b1;
        step();
        clr_err_i = 1'b0;
        swap_i    = 1'b0;
        check("ur_set_wins", {31'b0, l1_underrun}, 32'd1);
        check("ur_set_wins2", {31'b0, l2_underrun}, 32'd1);
        clear_err();
        check("ur_clear2", {31'b0, l1_underrun}, 32'd0);

        // Concurrency: swap + last write + read in one cycle
        write_line(32'h500, 7);
        check("cc_ready", {31'b0, l1_wr_ready}, 32'd1);
        wr_valid_i = 1'b1;
        wr_data_i  = 32'h507;
        swap_i     = 1'b1;
        rd_en_i    = 1'b1;
        rd_addr_i  = 4'd1;
        step();
        wr_valid_i = 1'b0;
        swap_i     = 1'b0;
        rd_en_i    = 1'b0;
        check("cc_rd1_old_front", l1_rd_data, 32'h411);
        check("cc_front", {31'b0, l1_front}, 32'd1);
        check("cc_fill_clr", {31'b0, l1_fill_done}, 32'd0);
        check("cc_underrun", {31'b0, l1_underrun}, 32'd1);
        check("cc_wptr_reset", {31'b0, l1_wr_ready}, 32'd1);
        step();
        check("cc_rd2_old_front", l2_rd_data, 32'h411);
        read_one(4'd7, 32'h507);
        read_one(4'd0, 32'h500);

        // Range: addresses beyond the line read as zero
        read_one(4'd8, 32'h0);
        read_one(4'd15, 32'h0);
        read_one(4'd7, 32'h507);

        // Reset mid-run clears state and read output
        rst = 1'b1;
        step();
        check("rst2_ready", {31'b0, l1_wr_ready}, 32'd0);
        check("rst2_front", {31'b0, l1_front}, 32'd0);
        check("rst2_underrun", {31'b0, l1_underrun}, 32'd0);
        check("rst2_rd1", l1_rd_data, 32'd0);
        check("rst2_rd2", l2_rd_data, 32'd0);
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
